// File: rtl/featuremap_source.sv
// featuremap_source: frame-buffer RAM streamed out in raster order.
// Define FEATUREMAP_SOURCE_GAP_EN for LINE_GAP idle cycles between rows.
module featuremap_source #(
    parameter int DWIDTH   = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int LINE_GAP = 4,
    localparam int NPIX    = IMG_W * IMG_H,
    // a 1x1 frame still needs one address bit
    localparam int AWIDTH  = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid_out,
    output logic              last_out,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(NPIX - 1);
    localparam logic [AWIDTH:0]   NPIX_W    = (AWIDTH + 1)'(NPIX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
`ifdef FEATUREMAP_SOURCE_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [AWIDTH-1:0]   addr_q;
`ifdef FEATUREMAP_SOURCE_GAP_EN
    localparam logic [7:0] GAP_LAST = 8'(LINE_GAP - 1);
    logic [7:0]          gap_q;
`endif

    logic [DWIDTH-1:0]   mem_q [NPIX];
    logic [DWIDTH-1:0]   rd_data_q;
    logic                rd_vld_q;
    logic                rd_last_q;

    logic [DWIDTH-1:0]   dout_q;
    logic                vld_q;
    logic                last_q;
    logic                done_q;
    logic                busy_q;
    logic                busy_d;

    logic                rd_en;
    logic                wr_ok;

    assign rd_en = (state_q == S_STREAM);
    assign wr_ok = wr_en && !busy_q && ({1'b0, wr_addr} < NPIX_W);

    // busy spans from the cycle after start to the frame_done pulse
    assign busy_d = done_q ? 1'b0 : (busy_q | (state_q != S_IDLE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
`ifdef FEATUREMAP_SOURCE_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !busy_q) begin
                        state_q <= S_STREAM;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                S_STREAM: begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (row_q == ROW_LAST) begin
                            row_q   <= '0;
                            addr_q  <= '0;
                            state_q <= S_DONE;
                        end else begin
                            row_q  <= row_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
`ifdef FEATUREMAP_SOURCE_GAP_EN
                            gap_q   <= '0;
                            state_q <= S_GAP;
`endif
                        end
                    end else begin
                        col_q  <= col_q + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
`ifdef FEATUREMAP_SOURCE_GAP_EN
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_STREAM;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM keeps its contents across reset
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[addr_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en && (addr_q == ADDR_LAST);
            dout_q    <= rd_vld_q ? rd_data_q : '0;
            vld_q     <= rd_vld_q;
            last_q    <= rd_last_q;
            done_q    <= last_q;
            busy_q    <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign data_out       = dout_q;
    assign data_valid_out = vld_q;
    assign last_out       = last_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_featuremap_source.sv
// Bench for featuremap_source: 28x28, 4x3 and 1x1 instances checked
// cycle by cycle against a pixel-schedule model of the frame.
module tb_featuremap_source;

    localparam int MAXC = 2048;
`ifdef FEATUREMAP_SOURCE_GAP_EN
    localparam int GON = 1;
`else
    localparam int GON = 0;
`endif
    localparam int G0 = 4 * GON;
    localparam int G1 = 4 * GON;

    logic       clock;
    logic       reset;
    logic       start;
    logic       start_s;
    logic       wr_en0, wr_en1, wr_en2;
    logic [9:0] wr_addr0;
    logic [3:0] wr_addr1;
    logic [0:0] wr_addr2;
    logic [7:0] wr_data0, wr_data1, wr_data2;

    logic [2:0] bz, vz, lz, fz;
    logic [7:0] dz [3];

    logic [11:0] obs   [3][MAXC];
    logic [11:0] exp_v [3][MAXC];
    logic [7:0]  mm    [3][784];
    logic [11:0] rst_snap;

    int bst [4];
    int sst [4];
    int wr_j;
    int rst_j;
    int tests_run;
    int tests_failed;

    featuremap_source #(.DWIDTH(8), .IMG_W(28), .IMG_H(28), .LINE_GAP(4)) u0 (
        .clock(clock), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .start(start), .busy(bz[0]), .data_out(dz[0]),
        .data_valid_out(vz[0]), .last_out(lz[0]), .frame_done(fz[0]));

    featuremap_source #(.DWIDTH(8), .IMG_W(4), .IMG_H(3), .LINE_GAP(4)) u1 (
        .clock(clock), .reset(reset), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .start(start_s), .busy(bz[1]), .data_out(dz[1]),
        .data_valid_out(vz[1]), .last_out(lz[1]), .frame_done(fz[1]));

    featuremap_source #(.DWIDTH(8), .IMG_W(1), .IMG_H(1), .LINE_GAP(4)) u2 (
        .clock(clock), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data2), .start(start_s), .busy(bz[2]), .data_out(dz[2]),
        .data_valid_out(vz[2]), .last_out(lz[2]), .frame_done(fz[2]));

    always #5 clock = ~clock;

    function automatic int fd_of(input int w, input int h, input int g);
        return 2 + (w * h - 1) + (h - 1) * g + 1;
    endfunction

    // Expected tuple {busy, frame_done, last, valid, data} per cycle.
    task automatic build(input int sel, input int w, input int h, input int g,
                         input int s0, input int s1, input int rj);
        int n;
        int s;
        int j;
        int fd;
        n = w * h;
        for (int c = 0; c < MAXC; c++) exp_v[sel][c] = '0;
        for (int q = 0; q < 2; q++) begin
            s = (q == 0) ? s0 : s1;
            if (s >= 0) begin
                for (int k = 0; k < n; k++) begin
                    j = s + 2 + k + (k / w) * g;
                    if (j < MAXC) begin
                        exp_v[sel][j][8]   = 1'b1;
                        exp_v[sel][j][7:0] = mm[sel][k];
                        exp_v[sel][j][9]   = (k == n - 1);
                    end
                end
                fd = s + fd_of(w, h, g);
                if (fd < MAXC) exp_v[sel][fd][10] = 1'b1;
                for (int b = s + 1; b <= fd && b < MAXC; b++)
                    exp_v[sel][b][11] = 1'b1;
            end
        end
        if (rj >= 0)
            for (int c = rj; c < MAXC; c++) exp_v[sel][c] = '0;
    endtask

    task automatic fill(input int mode);
        logic [7:0] d;
        for (int k = 0; k < 784; k++) begin
            @(negedge clock);
            d = (mode == 0) ? 8'(k) : 8'($urandom);
            wr_en0 = 1'b1; wr_addr0 = 10'(k); wr_data0 = d; mm[0][k] = d;
            wr_en1 = (k < 12);
            wr_en2 = (k < 1);
            if (k < 12) begin
                d = 8'($urandom);
                wr_addr1 = 4'(k); wr_data1 = d; mm[1][k] = d;
            end
            if (k < 1) begin
                d = 8'($urandom);
                wr_addr2 = 1'b0; wr_data2 = d; mm[2][0] = d;
            end
        end
        @(negedge clock);
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    task automatic capture(input int len);
        for (int j = 0; j < len; j++) begin
            @(negedge clock);
            start   = 1'b0;
            start_s = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (bst[i] == j) start = 1'b1;
                if (sst[i] == j) start_s = 1'b1;
            end
            wr_en0   = (j == wr_j);
            wr_addr0 = 10'd5;
            wr_data0 = 8'hFF;
            reset    = (j == rst_j);
            if (j == rst_j) begin
                #1;
                rst_snap = {bz[0], fz[0], lz[0], vz[0], dz[0]};
            end
            @(posedge clock);
            #1;
            for (int i = 0; i < 3; i++)
                obs[i][j] = {bz[i], fz[i], lz[i], vz[i], dz[i]};
        end
        @(negedge clock);
        start = 1'b0; start_s = 1'b0; wr_en0 = 1'b0; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin bst[i] = -1; sst[i] = -1; end
        wr_j = -1; rst_j = -1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({bz[i], fz[i], lz[i], vz[i], dz[i]} !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset u%0d: got %h want 000", i,
                         {bz[i], fz[i], lz[i], vz[i], dz[i]});
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_frame();
        int len;
        int nv;
        int nb;
        int k;
        fill(0);
        len = fd_of(28, 28, G0) + 4;
        bst[0] = 0; sst[0] = 0;
        capture(len);
        build(0, 28, 28, G0, 0, -1, -1);
        build(1, 4, 3, G1, 0, -1, -1);
        build(2, 1, 1, 0, 0, -1, -1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < len; j++) begin
                tests_run++;
                if (obs[i][j] !== exp_v[i][j]) begin
                    tests_failed++;
                    $display("FAIL frame u%0d cyc %0d: got %h want %h",
                             i, j, obs[i][j], exp_v[i][j]);
                end
            end
        nv = 0; nb = 0; k = 0;
        for (int j = 0; j < len; j++) begin
            if (obs[0][j][8]) begin
                tests_run++;
                if (obs[0][j][7:0] !== 8'(k)) begin
                    tests_failed++;
                    $display("FAIL order pixel %0d: got %0d want %0d",
                             k, obs[0][j][7:0], k % 256);
                end
                k++;
                nv++;
            end
            if (obs[1][j][11]) nb++;
        end
        tests_run++;
        if (nv != 784) begin
            tests_failed++;
            $display("FAIL valid count: got %0d want 784", nv);
        end
        tests_run++;
        if (nb != 12 + 2 + 2 * G1) begin
            tests_failed++;
            $display("FAIL busy len 4x3: got %0d want %0d", nb, 14 + 2 * G1);
        end
    endtask

    task automatic test_start_ignored();
        int fd;
        int len;
        fill(1);
        fd = fd_of(28, 28, G0);
        len = 2 * (fd + 2) + 4;
        bst[0] = 0;
        bst[1] = 2 + 100 + (100 / 28) * G0;
        bst[2] = fd + 1;
        bst[3] = fd + 2;
        capture(len);
        build(0, 28, 28, G0, 0, fd + 2, -1);
        for (int j = 0; j < len; j++) begin
            tests_run++;
            if (obs[0][j] !== exp_v[0][j]) begin
                tests_failed++;
                $display("FAIL start_ignore cyc %0d: got %h want %h",
                         j, obs[0][j], exp_v[0][j]);
            end
        end
    endtask

    task automatic test_write_dropped();
        int len;
        len = fd_of(28, 28, G0) + 4;
        for (int f = 0; f < 2; f++) begin
            bst[0] = 0;
            if (f == 0) wr_j = 12;
            capture(len);
            build(0, 28, 28, G0, 0, -1, -1);
            for (int j = 0; j < len; j++) begin
                tests_run++;
                if (obs[0][j] !== exp_v[0][j]) begin
                    tests_failed++;
                    $display("FAIL wr_drop f%0d cyc %0d: got %h want %h",
                             f, j, obs[0][j], exp_v[0][j]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int len;
        int rj;
        len = fd_of(28, 28, G0) + 4;
        rj = 2 + 300 + (300 / 28) * G0;
        bst[0] = 0;
        rst_j = rj;
        capture(len);
        tests_run++;
        if (rst_snap !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_async: got %h want 000", rst_snap);
        end
        build(0, 28, 28, G0, 0, -1, rj);
        for (int j = 0; j < len; j++) begin
            tests_run++;
            if (obs[0][j] !== exp_v[0][j]) begin
                tests_failed++;
                $display("FAIL reset_mid cyc %0d: got %h want %h",
                         j, obs[0][j], exp_v[0][j]);
            end
        end
        bst[0] = 0;
        capture(len);
        build(0, 28, 28, G0, 0, -1, -1);
        for (int j = 0; j < len; j++) begin
            tests_run++;
            if (obs[0][j] !== exp_v[0][j]) begin
                tests_failed++;
                $display("FAIL restart cyc %0d: got %h want %h",
                         j, obs[0][j], exp_v[0][j]);
            end
        end
    endtask

    task automatic test_small();
        int fd1;
        int len;
        int nl;
        fill(1);
        fd1 = fd_of(4, 3, G1);
        len = 2 * fd1 + 6;
        sst[0] = 0;
        sst[1] = fd1 + 1;
        sst[2] = fd1 + 2;
        capture(len);
        build(1, 4, 3, G1, 0, fd1 + 2, -1);
        build(2, 1, 1, 0, 0, fd1 + 1, -1);
        build(0, 28, 28, G0, -1, -1, -1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < len; j++) begin
                tests_run++;
                if (obs[i][j] !== exp_v[i][j]) begin
                    tests_failed++;
                    $display("FAIL small u%0d cyc %0d: got %h want %h",
                             i, j, obs[i][j], exp_v[i][j]);
                end
            end
        nl = 0;
        for (int j = 0; j < len; j++)
            if (obs[2][j][9] && obs[2][j][8]) nl++;
        tests_run++;
        if (nl != 2) begin
            tests_failed++;
            $display("FAIL 1x1 last count: got %0d want 2", nl);
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; start = 1'b0; start_s = 1'b0;
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; wr_addr2 = '0;
        wr_data0 = '0; wr_data1 = '0; wr_data2 = '0;
        for (int i = 0; i < 4; i++) begin bst[i] = -1; sst[i] = -1; end
        wr_j = -1; rst_j = -1;
        tests_run = 0; tests_failed = 0;
        repeat (2) @(negedge clock);
        test_reset();
        test_frame();
        test_start_ignored();
        test_write_dropped();
        test_reset_midframe();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, run %0d failed %0d",
                 tests_run, tests_failed);
        $fatal(1);
    end

endmodule
